load_store_unit: RTL and testbench

Sits between the execute stage and the word-addressed data memory and turns byte/halfword/word loads and stores into whole-word memory accesses. Loads are lane-extracted and sign- or zero-extended. Sub-word stores become a read-modify-write. Misaligned or illegal requests are flagged and never reach memory. The memory has a combinational read and a synchronous word write.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit_byte_lane.sv | 54 +++++
 rtl/load_store_unit.sv | 108 ++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   mem_size_t    - access size encoding carried on req_size
//   lsu_state_t   - control FSM states
//   is_misaligned - fault rule for a (size, addr[1:0]) pair
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    RESP  = 2'b10
  } lsu_state_t;

  // Size 2'b11 is not a legal encoding, so it always faults.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory bus of the load/store unit.
//   req_*  : execute-stage request (valid/ready handshake)
//   resp_* : one-cycle completion pulse with load data and fault flag
//   mem_*  : word memory port, combinational read, synchronous write
// Modports: slave = the load/store unit, master = its environment.
interface load_store_unit_if #(
  parameter int ADDR_W = 14
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic              mem_w_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_r_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_w_enable, mem_addr, mem_w_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_r_data,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_w_enable, mem_addr, mem_w_data
  );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// lsu_byte_lane: combinational lane logic shared by the load and store paths.
//   extract: i_ext_word/size/lane/unsigned -> o_ext_data (lane picked, extended)
//   merge  : i_mrg_old/new/size/lane       -> o_mrg_word (lane(s) replaced)
// Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_ext_word,
  input  logic [1:0]  i_ext_size,
  input  logic [1:0]  i_ext_lane,
  input  logic        i_ext_unsigned,
  output logic [31:0] o_ext_data,
  input  logic [31:0] i_mrg_old,
  input  logic [31:0] i_mrg_new,
  input  logic [1:0]  i_mrg_size,
  input  logic [1:0]  i_mrg_lane,
  output logic [31:0] o_mrg_word
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_src;
  logic [3:0]  w_be;

  assign w_byte = i_ext_word[{i_ext_lane, 3'b000} +: 8];
  assign w_half = i_ext_word[{i_ext_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_ext_data = i_ext_word;
    case (mem_size_t'(i_ext_size))
      SZ_BYTE: o_ext_data = {{24{~i_ext_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ext_data = {{16{~i_ext_unsigned & w_half[15]}}, w_half};
      default: o_ext_data = i_ext_word;
    endcase
  end

  // Replicate the store data into every lane; the byte enables pick which lanes take it.
  always_comb begin
    w_src = i_mrg_new;
    case (mem_size_t'(i_mrg_size))
      SZ_BYTE: w_src = {4{i_mrg_new[7:0]}};
      SZ_HALF: w_src = {2{i_mrg_new[15:0]}};
      default: w_src = i_mrg_new;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_be[gi] = ((i_mrg_size == 2'b00) && (i_mrg_lane == 2'(gi))) ||
                        ((i_mrg_size == 2'b01) && (i_mrg_lane[1] == (gi >= 2))) ||
                        (i_mrg_size == 2'b10);
      assign o_mrg_word[8*gi +: 8] = w_be[gi] ? w_src[8*gi +: 8] : i_mrg_old[8*gi +: 8];
    end
  endgenerate
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word loads and stores into whole-word
// memory accesses. Loads complete in one cycle, sub-word stores are a
// read-modify-write through the WRITE state, faults never touch memory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/response handshake and data-memory port (slave side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);
  lsu_state_t        r_state;
  lsu_state_t        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_misaligned;
  logic              w_accept;
  logic              w_fault;
  logic [31:0]       w_extracted;
  logic [31:0]       w_merged;

  assign w_accept = bus.req_valid && (r_state == IDLE);
  assign w_fault  = is_misaligned(bus.req_size, bus.req_addr[1:0]);

  // Extraction works on the live request (IDLE), merging on the registered store.
  lsu_byte_lane u_lane (
    .i_ext_word     (bus.mem_r_data),
    .i_ext_size     (bus.req_size),
    .i_ext_lane     (bus.req_addr[1:0]),
    .i_ext_unsigned (bus.req_unsigned),
    .o_ext_data     (w_extracted),
    .i_mrg_old      (bus.mem_r_data),
    .i_mrg_new      (r_wdata),
    .i_mrg_size     (r_size),
    .i_mrg_lane     (r_addr[1:0]),
    .o_mrg_word     (w_merged)
  );

  always_comb begin
    w_state_next        = r_state;
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.mem_w_enable    = 1'b0;
    bus.mem_addr        = bus.req_addr;
    bus.mem_w_data      = '0;
    bus.resp_rdata      = r_resp_rdata;
    bus.resp_misaligned = r_resp_misaligned;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          w_state_next = (bus.req_we && !w_fault) ? WRITE : RESP;
        end
      end
      WRITE: begin
        bus.mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
        bus.mem_w_data   = w_merged;
        bus.mem_w_enable = 1'b1;
        w_state_next     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Reset is asynchronous so an in-flight WRITE drops mem_w_enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_addr            <= '0;
      r_size            <= '0;
      r_wdata           <= '0;
      r_resp_rdata      <= '0;
      r_resp_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_fault) begin
              r_resp_misaligned <= 1'b1;
              r_resp_rdata      <= '0;
            end else if (bus.req_we) begin
              r_resp_misaligned <= 1'b0;
              r_addr            <= bus.req_addr;
              r_size            <= bus.req_size;
              r_wdata           <= bus.req_wdata;
            end else begin
              r_resp_misaligned <= 1'b0;
              r_resp_rdata      <= w_extracted;
            end
          end
        end
        WRITE: r_resp_rdata <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  load_store_unit_if #(.ADDR_W(14)) bus ();

  load_store_unit #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, synchronous write, plus a backdoor preload port.
  logic [31:0] mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_idx;
  logic [31:0] bd_data;
  assign bus.mem_r_data = mem[bus.mem_addr[13:2]];
  always @(posedge clk) begin
    if (bus.mem_w_enable) mem[bus.mem_addr[13:2]] <= bus.mem_w_data;
    else if (bd_we)       mem[bd_idx] <= bd_data;
  end

  // Reference model: word array updated by the architectural load/store rules.
  logic [31:0] ref_mem [0:63];

  function automatic void ref_access(input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [13:0] addr, input logic [31:0] wd,
                                     output logic [31:0] er, output logic em,
                                     output int el, output int ew);
    int          nbytes;
    int          sh;
    logic [31:0] mask;
    logic [31:0] v;
    int          widx;
    widx = int'(addr[7:2]);
    sh   = 8 * int'(addr[1:0]);
    er = 0; em = 0; el = 1; ew = 0;
    if (sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)) begin
      em = 1;
    end else begin
      nbytes = 1 << sz;
      mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (we) begin
        ref_mem[widx] = (ref_mem[widx] & ~(mask << sh)) | ((wd & mask) << sh);
        el = 2; ew = 1;
      end else begin
        v = (ref_mem[widx] >> sh) & mask;
        if (!uns && ((v & (mask ^ (mask >> 1))) != 0)) v = v | ~mask;
        er = v;
      end
    end
  endfunction

  // Issues one request from an IDLE cycle and observes the response; returns at posedge+1 in IDLE.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [13:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic mis,
                        output int lat, output int wr_seen);
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; wr_seen = 0;
    while (!bus.resp_valid && lat < 6) begin
      if (bus.mem_w_enable) wr_seen++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata;
    mis   = bus.resp_misaligned;
    if (!bus.resp_valid) lat = -1;
    $display("txn we=%0d sz=%0d uns=%0d addr=%h wdata=%h -> rdata=%h mis=%0d lat=%0d writes=%0d",
             we, sz, uns, addr, wd, rdata, mis, lat, wr_seen);
    @(posedge clk); #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) begin
      bd_idx  = 12'(i);
      bd_data = (i == 8) ? 32'h1122_3344 : $urandom;
      ref_mem[i] = bd_data;
      bd_we = 1'b1;
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bd_we = 0; bd_idx = 0; bd_data = 0;
    #1;
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid_async got=%b exp=0", bus.resp_valid); end
    vectors++; if (bus.mem_w_enable !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we_async got=%b exp=0", bus.mem_w_enable); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    vectors++; if (bus.resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
    vectors++; if (bus.resp_misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned got=%b exp=0", bus.resp_misaligned); end
    vectors++; if (bus.mem_w_data !== 32'h0) begin miscompares++; $display("FAIL reset_mem_w_data got=%h exp=0", bus.mem_w_data); end
    $display("txn reset released");
  endtask

  task automatic test_word_store_load();
    logic [31:0] r, er; logic m, em; int l, w, el, ew;
    do_req(1, 2'd2, 0, 14'h0010, 32'hDEAD_BEEF, r, m, l, w);
    ref_access(1, 2'd2, 0, 14'h0010, 32'hDEAD_BEEF, er, em, el, ew);
    vectors++; if (l !== 2) begin miscompares++; $display("FAIL store_word_latency got=%0d exp=2", l); end
    vectors++; if (w !== 1) begin miscompares++; $display("FAIL store_word_writes got=%0d exp=1", w); end
    vectors++; if (m !== 1'b0 || r !== 32'h0) begin miscompares++; $display("FAIL store_word_resp got=%h/%b exp=0/0", r, m); end
    vectors++; if (mem[4] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL store_word_mem got=%h exp=deadbeef", mem[4]); end
    do_req(0, 2'd2, 0, 14'h0010, 0, r, m, l, w);
    ref_access(0, 2'd2, 0, 14'h0010, 0, er, em, el, ew);
    vectors++; if (l !== 1) begin miscompares++; $display("FAIL load_word_latency got=%0d exp=1", l); end
    vectors++; if (r !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_word_data got=%h exp=deadbeef", r); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] r, er; logic m, em; int l, w, el, ew;
    do_req(1, 2'd0, 0, 14'h0012, 32'h0000_0055, r, m, l, w);
    ref_access(1, 2'd0, 0, 14'h0012, 32'h0000_0055, er, em, el, ew);
    vectors++; if (l !== 2 || w !== 1) begin miscompares++; $display("FAIL store_byte_timing got=%0d/%0d exp=2/1", l, w); end
    do_req(0, 2'd2, 0, 14'h0010, 0, r, m, l, w);
    ref_access(0, 2'd2, 0, 14'h0010, 0, er, em, el, ew);
    vectors++; if (r !== 32'hDE55_BEEF) begin miscompares++; $display("FAIL byte_merge_data got=%h exp=de55beef", r); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] r, er; logic m, em; int l, w, el, ew;
    do_req(0, 2'd0, 0, 14'h0013, 0, r, m, l, w);
    ref_access(0, 2'd0, 0, 14'h0013, 0, er, em, el, ew);
    vectors++; if (r !== 32'hFFFF_FFDE) begin miscompares++; $display("FAIL lb_signed got=%h exp=ffffffde", r); end
    do_req(0, 2'd0, 1, 14'h0013, 0, r, m, l, w);
    ref_access(0, 2'd0, 1, 14'h0013, 0, er, em, el, ew);
    vectors++; if (r !== 32'h0000_00DE) begin miscompares++; $display("FAIL lb_unsigned got=%h exp=000000de", r); end
    do_req(0, 2'd1, 0, 14'h0010, 0, r, m, l, w);
    ref_access(0, 2'd1, 0, 14'h0010, 0, er, em, el, ew);
    vectors++; if (r !== 32'hFFFF_BEEF) begin miscompares++; $display("FAIL lh_signed got=%h exp=ffffbeef", r); end
    do_req(0, 2'd1, 1, 14'h0012, 0, r, m, l, w);
    ref_access(0, 2'd1, 1, 14'h0012, 0, er, em, el, ew);
    vectors++; if (r !== 32'h0000_DE55) begin miscompares++; $display("FAIL lhu_upper got=%h exp=0000de55", r); end
  endtask

  task automatic test_faults();
    logic [31:0] r, er; logic m, em; int l, w, el, ew;
    do_req(0, 2'd1, 0, 14'h0011, 0, r, m, l, w);
    vectors++; if (m !== 1'b1 || r !== 32'h0 || l !== 1) begin miscompares++; $display("FAIL fault_half_load got=%h/%b/%0d exp=0/1/1", r, m, l); end
    do_req(1, 2'd2, 0, 14'h0016, 32'hCAFE_F00D, r, m, l, w);
    ref_access(1, 2'd2, 0, 14'h0016, 32'hCAFE_F00D, er, em, el, ew);
    vectors++; if (m !== 1'b1 || w !== 0 || l !== 1) begin miscompares++; $display("FAIL fault_word_store got=%b/%0d/%0d exp=1/0/1", m, w, l); end
    vectors++; if (mem[5] !== ref_mem[5]) begin miscompares++; $display("FAIL fault_store_mem got=%h exp=%h", mem[5], ref_mem[5]); end
    do_req(0, 2'd3, 0, 14'h0010, 0, r, m, l, w);
    vectors++; if (m !== 1'b1 || r !== 32'h0) begin miscompares++; $display("FAIL fault_size3_load got=%h/%b exp=0/1", r, m); end
    do_req(1, 2'd3, 0, 14'h0014, 32'h1234_5678, r, m, l, w);
    vectors++; if (m !== 1'b1 || w !== 0 || mem[5] !== ref_mem[5]) begin miscompares++; $display("FAIL fault_size3_store got=%b/%0d exp=1/0", m, w); end
    do_req(0, 2'd2, 0, 14'h0010, 0, r, m, l, w);
    vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL fault_flag_clears got=%b exp=0", m); end
  endtask

  task automatic test_reset_in_write();
    logic [31:0] r, er; logic m, em; int l, w, el, ew;
    bus.req_we = 1; bus.req_size = 2'd0; bus.req_unsigned = 0;
    bus.req_addr = 14'h0020; bus.req_wdata = 32'h0000_00AA; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    vectors++; if (bus.mem_w_enable !== 1'b1) begin miscompares++; $display("FAIL rstw_in_write got=%b exp=1", bus.mem_w_enable); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.mem_w_enable !== 1'b0) begin miscompares++; $display("FAIL rstw_we_drop got=%b exp=0", bus.mem_w_enable); end
    @(posedge clk); #1;
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rstw_no_resp got=%b exp=0", bus.resp_valid); end
    vectors++; if (mem[8] !== 32'h1122_3344) begin miscompares++; $display("FAIL rstw_mem got=%h exp=11223344", mem[8]); end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rstw_no_late_resp got=%b exp=0", bus.resp_valid); end
    $display("txn reset during WRITE to addr=0020");
    do_req(0, 2'd2, 0, 14'h0020, 0, r, m, l, w);
    ref_access(0, 2'd2, 0, 14'h0020, 0, er, em, el, ew);
    vectors++; if (r !== 32'h1122_3344) begin miscompares++; $display("FAIL rstw_reload got=%h exp=11223344", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, er, wd; logic m, em, we, uns; int l, w, el, ew;
    logic [1:0] sz; logic [13:0] a;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      a = 14'($urandom_range(0, 255)); wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(we, sz, uns, a, wd, r, m, l, w);
      ref_access(we, sz, uns, a, wd, er, em, el, ew);
      vectors++;
      if (r !== er || m !== em || l !== el || w !== ew) begin
        miscompares++;
        $display("FAIL random_%0d got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", i, r, m, l, w, er, em, el, ew);
      end
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (mem[i] !== ref_mem[i]) begin miscompares++; $display("FAIL random_mem_%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic        we_l  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz_l  [3] = '{2'd2, 2'd1, 2'd2};
    logic [13:0] ad_l  [3] = '{14'h0024, 14'h0026, 14'h0024};
    logic [31:0] wd_l  [3] = '{32'h0, 32'h0000_1234, 32'h0};
    logic [5:0]  pat = 6'b100101;
    logic [31:0] exp_q[$];
    logic [31:0] er, e; logic em; int el, ew;
    int k = 0;
    int nresp = 0;
    bus.req_we = we_l[0]; bus.req_size = sz_l[0]; bus.req_unsigned = 0;
    bus.req_addr = ad_l[0]; bus.req_wdata = wd_l[0]; bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 6) begin
        vectors++;
        if (bus.req_ready !== pat[cyc]) begin miscompares++; $display("FAIL b2b_ready_c%0d got=%b exp=%b", cyc, bus.req_ready, pat[cyc]); end
      end
      if (bus.resp_valid) begin
        nresp++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra_resp got=%h exp=none", bus.resp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.resp_rdata !== e) begin miscompares++; $display("FAIL b2b_resp_%0d got=%h exp=%h", nresp, bus.resp_rdata, e); end
        end
        $display("txn b2b resp %0d rdata=%h", nresp, bus.resp_rdata);
      end
      if (bus.req_ready && bus.req_valid) begin
        ref_access(we_l[k], sz_l[k], 1'b0, ad_l[k], wd_l[k], er, em, el, ew);
        exp_q.push_back(er);
        k++;
      end
      @(posedge clk); #1;
      if (k < 3) begin
        bus.req_we = we_l[k]; bus.req_size = sz_l[k];
        bus.req_addr = ad_l[k]; bus.req_wdata = wd_l[k];
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    vectors++; if (nresp !== 3 || k !== 3) begin miscompares++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", nresp, k); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    preload();
    test_word_store_load();
    test_byte_merge();
    test_sign_ext();
    test_faults();
    test_reset_in_write();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
